// File: rtl/iq_demod_param.sv
// iq_demod_param: fs/4 I/Q demodulator with an integrated quarter-rate LO.
// Rotates each accepted I/Q sample by the LO phase (direction set by DIR),
// using saturating negation with a sticky overflow flag. Output is
// registered with one cycle of latency.
// Optional feature macro: IQ_DEMOD_AVG_EN (2-tap averaging output stage).
module iq_demod_param #(
    parameter int unsigned W      = 7,
    parameter int unsigned DIR    = 0,
    parameter int unsigned PHASE0 = 0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ADC_rdy,
    input  logic signed [W-1:0] I_IF,
    input  logic signed [W-1:0] Q_IF,
    input  logic                phase_clr,
    output logic signed [W-1:0] I_BB,
    output logic signed [W-1:0] Q_BB,
    output logic                demod_rdy,
    output logic [1:0]          lo_phase,
    output logic                ovf
);

    typedef enum logic [1:0] {
        PH_0 = 2'd0,
        PH_1 = 2'd1,
        PH_2 = 2'd2,
        PH_3 = 2'd3
    } phase_e;

    localparam logic [1:0]          PH0   = 2'(PHASE0);
    localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};

    // Saturating negation: returns {saturated, -x}
    function automatic logic [W:0] neg_sat(input logic signed [W-1:0] x);
        if (x == S_MIN) begin
            return {1'b1, S_MAX};
        end
        return {1'b0, -x};
    endfunction

    phase_e              phase_q, phase_d;
    logic                ovf_q, ovf_d;
    logic                demod_rdy_q, demod_rdy_d;
    logic signed [W-1:0] i_bb_q, i_bb_d;
    logic signed [W-1:0] q_bb_q, q_bb_d;

    logic [1:0]          phase_use;
    logic [1:0]          rot;
    logic [W:0]          neg_i, neg_q;
    logic signed [W-1:0] mix_i, mix_q;
    logic                sat;
    logic signed [W-1:0] out_i, out_q;

    // Mixer: pick the LO phase for this sample and rotate the input
    always_comb begin
        phase_use = phase_clr ? PH0 : phase_q;
        // The conjugate rotation is the forward rotation at phase -p (mod 4)
        rot   = (DIR != 0) ? 2'(2'd0 - phase_use) : phase_use;
        neg_i = neg_sat(I_IF);
        neg_q = neg_sat(Q_IF);
        mix_i = I_IF;
        mix_q = Q_IF;
        sat   = 1'b0;
        case (rot)
            2'd0: begin
                mix_i = I_IF;
                mix_q = Q_IF;
            end
            2'd1: begin
                mix_i = Q_IF;
                mix_q = neg_i[W-1:0];
                sat   = neg_i[W];
            end
            2'd2: begin
                mix_i = neg_i[W-1:0];
                mix_q = neg_q[W-1:0];
                sat   = neg_i[W] | neg_q[W];
            end
            default: begin
                mix_i = neg_q[W-1:0];
                mix_q = I_IF;
                sat   = neg_q[W];
            end
        endcase
    end

`ifdef IQ_DEMOD_AVG_EN
    logic signed [W-1:0] hist_i_q, hist_i_d;
    logic signed [W-1:0] hist_q_q, hist_q_d;
    logic signed [W-1:0] hist_i_use, hist_q_use;
    logic signed [W:0]   sum_i, sum_q;

    // 2-tap average; a coincident phase_clr averages against cleared history
    always_comb begin
        hist_i_use = phase_clr ? '0 : hist_i_q;
        hist_q_use = phase_clr ? '0 : hist_q_q;
        sum_i      = {mix_i[W-1], mix_i} + {hist_i_use[W-1], hist_i_use};
        sum_q      = {mix_q[W-1], mix_q} + {hist_q_use[W-1], hist_q_use};
        out_i      = sum_i[W:1];
        out_q      = sum_q[W:1];
        hist_i_d   = hist_i_q;
        hist_q_d   = hist_q_q;
        if (ADC_rdy) begin
            hist_i_d = mix_i;
            hist_q_d = mix_q;
        end else if (phase_clr) begin
            hist_i_d = '0;
            hist_q_d = '0;
        end
    end

    // Averaging history registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist_i_q <= '0;
            hist_q_q <= '0;
        end else begin
            hist_i_q <= hist_i_d;
            hist_q_q <= hist_q_d;
        end
    end
`else
    // Direct output: mixed sample passes straight to the output register
    always_comb begin
        out_i = mix_i;
        out_q = mix_q;
    end
`endif

    // Next-state: phase advance, sticky overflow, output capture
    always_comb begin
        phase_d     = phase_q;
        ovf_d       = ovf_q;
        demod_rdy_d = ADC_rdy;
        i_bb_d      = i_bb_q;
        q_bb_d      = q_bb_q;
        if (ADC_rdy) begin
            phase_d = phase_e'(phase_use + 2'd1);
            ovf_d   = (ovf_q & ~phase_clr) | sat;
            i_bb_d  = out_i;
            q_bb_d  = out_q;
        end else if (phase_clr) begin
            phase_d = phase_e'(PH0);
            ovf_d   = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_q     <= phase_e'(PH0);
            ovf_q       <= 1'b0;
            demod_rdy_q <= 1'b0;
            i_bb_q      <= '0;
            q_bb_q      <= '0;
        end else begin
            phase_q     <= phase_d;
            ovf_q       <= ovf_d;
            demod_rdy_q <= demod_rdy_d;
            i_bb_q      <= i_bb_d;
            q_bb_q      <= q_bb_d;
        end
    end

    assign I_BB      = i_bb_q;
    assign Q_BB      = q_bb_q;
    assign demod_rdy = demod_rdy_q;
    assign lo_phase  = phase_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/iq_demod_param.md
# iq_demod_param

Parametrised fs/4 I/Q demodulator with an integrated quarter-rate local oscillator. It replaces the fixed 7-bit `demodulation` + `fsm` pair in the receive chain, between the ADC interface (I/Q IF samples with `ADC_rdy` strobe) and the baseband filter/despreader. It adds:
- generic sample width;
- selectable rotation direction;
- programmable start phase with synchronous phase clear;
- saturating negation with a sticky overflow flag;
- an optional 2-tap averaging output stage.

## Interface
Parameters:
- `W`, 7, sample width (two's complement) for I/Q in and out; valid range 4..16.
- `DIR`, 0, rotation direction: 0 = multiply by e^(-jπn/2) (down-conversion), 1 = multiply by e^(+jπn/2).
- `PHASE0`, 0, LO phase (0..3) loaded at reset and on `phase_clr`.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `resetn`  in  1  asynchronous, active-low reset.
- `ADC_rdy`  in  1  sample-valid strobe; `I_IF`/`Q_IF` are valid in the same cycle.
- `I_IF`  in  W  in-phase IF sample, signed.
- `Q_IF`  in  W  quadrature IF sample, signed.
- `phase_clr`  in  1  synchronous LO phase reload to `PHASE0`; also clears `ovf`.
- `I_BB`  out  W  in-phase baseband output, signed, registered.
- `Q_BB`  out  W  quadrature baseband output, signed, registered.
- `demod_rdy`  out  1  one-cycle pulse: new `I_BB`/`Q_BB` valid.
- `lo_phase`  out  2  current LO phase index (debug).
- `ovf`  out  1  sticky flag: a negation saturated.

## Operation
- LO phase counter `p` is 2 bits, modulo 4. It holds unless a sample is accepted or `phase_clr` is asserted.
- Sample accepted on each rising edge with `ADC_rdy`=1. Mixing per phase p of that sample, with DIR=0 (I,Q inputs):
  - p0: (I, Q)
  - p1: (Q, −I)
  - p2: (−I, −Q)
  - p3: (−Q, I)
- DIR=1 uses the conjugate rotation:
  - p0: (I, Q)
  - p1: (−Q, I)
  - p2: (−I, −Q)
  - p3: (Q, −I)
- Negation is saturating: −(−2^(W−1)) yields 2^(W−1)−1 and sets `ovf`. No other overflow is possible.
- After an accepted sample, `p` ← p+1 (3 wraps to 0).
- `phase_clr` without `ADC_rdy`: `p` ← `PHASE0`, `ovf` ← 0.
- `phase_clr` and `ADC_rdy` in the same cycle:
  - the sample is mixed with phase `PHASE0`;
  - `p` ← `PHASE0`+1;
  - `ovf` ← saturation result of that sample only.
- `I_BB`/`Q_BB` hold their value between accepted samples.

## Timing
- Reset values (async, immediate):
  - `I_BB`=0, `Q_BB`=0;
  - `demod_rdy`=0;
  - `ovf`=0;
  - `lo_phase`=`PHASE0`;
  - averaging history = 0.
- Latency is 1 cycle. A sample presented with `ADC_rdy` in cycle k appears on `I_BB`/`Q_BB` in cycle k+1, with `demod_rdy`=1 in cycle k+1 only.
- Strobe spacing is arbitrary. `ADC_rdy` may be high every cycle; this gives a continuous `demod_rdy`, one output per cycle.
- Reset asserted mid-stream drops any in-flight sample. Phase restarts at `PHASE0` on the first strobe after `resetn` rises.
- `lo_phase` reflects the phase the next accepted sample will use.

## Configuration
- Macro `IQ_DEMOD_AVG_EN`.
- Defined: the output is the 2-tap average of consecutive mixed samples, computed per channel as `(mix[n] + mix[n−1]) >>> 1`.
  - The sum is W+1 bits; the arithmetic shift rounds toward −∞.
  - History updates only on accepted samples and is cleared by reset and by `phase_clr`.
  - Latency stays 1 cycle.
- Not defined: the output is the mixed sample directly; no history registers are built.

## Test plan
All scenarios use W=7, PHASE0=0 unless stated.
- Reset: hold `resetn`=0 → `I_BB`=`Q_BB`=0, `demod_rdy`=0, `ovf`=0, `lo_phase`=0. Then release and send no strobes → outputs stay 0.
- Rotation, DIR=0: I=10, Q=3 with `ADC_rdy` every 5th cycle, 4 strobes → outputs (10,3), (3,−10), (−10,−3), (−3,10). Each pulse of `demod_rdy` is one cycle after its strobe; `lo_phase` returns to 0.
- Rotation, DIR=1: same stimulus → outputs (10,3), (−3,10), (−10,−3), (3,−10). Also repeat with `ADC_rdy` high every cycle → identical values on consecutive cycles.
- Saturation: I=−64, Q=0 at p2 → `I_BB`=63, `Q_BB`=0, `ovf`=1 stays high. A later `phase_clr` → `ovf`=0, `lo_phase`=0.
- Coincident clear: `phase_clr` and `ADC_rdy` together at p2, I=5, Q=−7 → output (5,−7), `lo_phase`=1. Also assert `resetn`=0 between strobes → outputs are 0 immediately, and the next sample uses p0.
- `IQ_DEMOD_AVG_EN` defined: I=10, Q=3 on two strobes from reset → (5,1), then (6,−4).
